// File: rtl/io_pkg.sv
// Shared types and default widths for the console I/O and halt sequencer.
package io_pkg;

    localparam int unsigned DataWDefault     = 32;
    localparam int unsigned SwWDefault       = 16;
    localparam int unsigned DebounceDefault  = 16;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitIn  = 2'd1,
        StCapture = 2'd2,
        StHalted  = 2'd3
    } io_state_e;

endpackage

// File: rtl/io_debounce.sv
// Counter-based level filter for the synchronised confirm button.
// Only built when IO_DEBOUNCE_EN is defined.
`ifdef IO_DEBOUNCE_EN
module io_debounce #(
    parameter int unsigned Cycles = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic sig_i,
    output logic sig_o
);

    localparam int unsigned CntW = $clog2(Cycles + 1);

    logic [CntW-1:0] cnt_q;
    logic            level_q;

    // The level follows the input only after Cycles consecutive disagreeing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else if (sig_i != level_q) begin
            if (cnt_q == CntW'(Cycles - 1)) begin
                level_q <= sig_i;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            cnt_q <= '0;
        end
    end

    assign sig_o = level_q;

endmodule
`endif

// File: rtl/io_unit.sv
// Console I/O and halt sequencer: stalls Input until operator confirmation, latches Output.
// Define IO_DEBOUNCE_EN to insert io_debounce between the synchroniser and the edge detector.
module io_unit
    import io_pkg::*;
#(
    parameter int unsigned DATA_W          = DataWDefault,
    parameter int unsigned SW_W            = SwWDefault,
    parameter int unsigned DEBOUNCE_CYCLES = DebounceDefault
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              input_flag,
    input  logic              output_flag,
    input  logic              halt,
    input  logic [SW_W-1:0]   switches,
    input  logic              confirm_btn,
    input  logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] in_data,
    output logic              in_valid,
    output logic              stall,
    output logic [DATA_W-1:0] display,
    output logic              display_valid,
    output logic              waiting_input,
    output logic              halted
);

    if (SW_W > DATA_W || DEBOUNCE_CYCLES == 0) begin : gen_bad_cfg
        $error("io_unit: SW_W must not exceed DATA_W and DEBOUNCE_CYCLES must be nonzero");
    end

    logic sync1_q;
    logic btn_s_q;
    logic btn_l;
    logic btn_d_q;
    logic press;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            btn_s_q <= 1'b0;
            btn_d_q <= 1'b0;
        end else begin
            sync1_q <= confirm_btn;
            btn_s_q <= sync1_q;
            btn_d_q <= btn_l;
        end
    end

`ifdef IO_DEBOUNCE_EN
    io_debounce #(
        .Cycles (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock (clock),
        .reset (reset),
        .sig_i (btn_s_q),
        .sig_o (btn_l)
    );
`else
    assign btn_l = btn_s_q;
`endif

    assign press = btn_l & ~btn_d_q;

    io_state_e         state_q, state_d;
    logic [DATA_W-1:0] in_data_q, in_data_d;
    logic [DATA_W-1:0] display_q, display_d;
    logic              display_valid_q, display_valid_d;

    always_comb begin
        state_d         = state_q;
        in_data_d       = in_data_q;
        display_d       = display_q;
        display_valid_d = display_valid_q;
        stall           = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Halt beats Input beats Output.
                if (halt) begin
                    state_d = StHalted;
                    stall   = 1'b1;
                end else if (input_flag) begin
                    state_d = StWaitIn;
                    stall   = 1'b1;
                end else if (output_flag) begin
                    display_d       = out_data;
                    display_valid_d = 1'b1;
                end
            end
            StWaitIn: begin
                stall = 1'b1;
                if (press) begin
                    in_data_d = DATA_W'(switches);
                    state_d   = StCapture;
                end
            end
            // Commit cycle: back to idle even though input_flag is still high.
            StCapture: state_d = StIdle;
            StHalted:  stall   = 1'b1;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= StIdle;
            in_data_q       <= '0;
            display_q       <= '0;
            display_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            in_data_q       <= in_data_d;
            display_q       <= display_d;
            display_valid_q <= display_valid_d;
        end
    end

    assign in_data       = in_data_q;
    assign in_valid      = (state_q == StCapture);
    assign display       = display_q;
    assign display_valid = display_valid_q;
    assign waiting_input = (state_q == StWaitIn);
    assign halted        = (state_q == StHalted);

endmodule

// File: tb/tb_io_unit.sv
// Self-checking bench for io_unit: directed steps plus randomized Input/Output transactions.
module tb_io_unit;

    localparam int DB = 4;
`ifdef IO_DEBOUNCE_EN
    localparam int LAT = 2 + DB;
`else
    localparam int LAT = 2;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        input_flag, output_flag, halt, confirm_btn;
    logic [15:0] switches;
    logic [31:0] out_data;
    logic [31:0] in_data, display;
    logic        in_valid, stall, display_valid, waiting_input, halted;

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level expectations.
    logic [31:0] exp_in_data;
    logic [31:0] exp_display;
    logic        exp_dv;

    io_unit #(
        .DATA_W          (32),
        .SW_W            (16),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .input_flag    (input_flag),
        .output_flag   (output_flag),
        .halt          (halt),
        .switches      (switches),
        .confirm_btn   (confirm_btn),
        .out_data      (out_data),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .stall         (stall),
        .display       (display),
        .display_valid (display_valid),
        .waiting_input (waiting_input),
        .halted        (halted)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".in_data"}, in_data, exp_in_data);
        chk({tag, ".display"}, display, exp_display);
        chk({tag, ".display_valid"}, {31'b0, display_valid}, {31'b0, exp_dv});
    endtask

    // Call while already waiting for input with the button released and settled.
    task automatic press_and_expect(input logic [15:0] sw, input bit keep);
        switches    = sw;
        confirm_btn = 1'b1;
        for (int c = 0; c <= LAT + 1; c++) begin
            tick();
            if (c == LAT) exp_in_data = {16'h0, sw};
            if (c == LAT + 1 && !keep) begin
                input_flag  = 1'b0;
                confirm_btn = 1'b0;
            end
            #1;
            chk("cap.in_valid", {31'b0, in_valid}, (c == LAT) ? 32'd1 : 32'd0);
            chk("cap.stall", {31'b0, stall},
                ((c < LAT) || (c == LAT + 1 && keep)) ? 32'd1 : 32'd0);
            chk("cap.waiting", {31'b0, waiting_input}, (c < LAT) ? 32'd1 : 32'd0);
            chk("cap.in_data", in_data, exp_in_data);
        end
    endtask

    task automatic settle_idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("idle.in_valid", {31'b0, in_valid}, 32'd0);
            chk("idle.stall", {31'b0, stall}, 32'd0);
            chk_regs("idle");
        end
    endtask

    task automatic do_output(input logic [31:0] v);
        output_flag = 1'b1;
        out_data    = v;
        #1;
        chk("out.stall_pre", {31'b0, stall}, 32'd0);
        tick();
        output_flag = 1'b0;
        exp_display = v;
        exp_dv      = 1'b1;
        #1;
        chk("out.stall", {31'b0, stall}, 32'd0);
        chk_regs("out");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset       = 1'b0;
        exp_in_data = '0;
        exp_display = '0;
        exp_dv      = 1'b0;
        #1;
        chk("rst.in_valid", {31'b0, in_valid}, 32'd0);
        chk("rst.waiting", {31'b0, waiting_input}, 32'd0);
        chk("rst.halted", {31'b0, halted}, 32'd0);
        chk("rst.stall", {31'b0, stall}, 32'd0);
        chk_regs("rst");
    endtask

    initial begin
        logic [15:0] sw;
        logic [31:0] v;
        int          w;

        input_flag  = 1'b0;
        output_flag = 1'b0;
        halt        = 1'b0;
        confirm_btn = 1'b0;
        switches    = '0;
        out_data    = '0;

        // Reset and output.
        do_reset();
        do_output(32'h0000_00A5);
        settle_idle(2);

        // Single input, button after 5 waiting cycles.
        input_flag = 1'b1;
        switches   = 16'h1234;
        #1;
        chk("in.stall_idle", {31'b0, stall}, 32'd1);
        chk("in.waiting_idle", {31'b0, waiting_input}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("in.waiting", {31'b0, waiting_input}, 32'd1);
            chk("in.stall", {31'b0, stall}, 32'd1);
        end
        press_and_expect(16'h1234, 1'b0);
        settle_idle(LAT + 2);

        // Back-to-back inputs with the button held.
        input_flag = 1'b1;
        tick();
        press_and_expect(16'h0001, 1'b1);
        switches = 16'h0002;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b2b.held_waiting", {31'b0, waiting_input}, 32'd1);
            chk("b2b.held_in_valid", {31'b0, in_valid}, 32'd0);
            chk("b2b.held_in_data", in_data, exp_in_data);
        end
        confirm_btn = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            tick();
            chk("b2b.rel_waiting", {31'b0, waiting_input}, 32'd1);
            chk("b2b.rel_in_valid", {31'b0, in_valid}, 32'd0);
        end
        press_and_expect(16'h0002, 1'b0);
        settle_idle(LAT + 2);

        // Randomized Input/Output transactions.
        for (int t = 0; t < 8; t++) begin
            v  = $urandom;
            sw = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                do_output(v);
                settle_idle(1);
            end else begin
                input_flag = 1'b1;
                w          = $urandom_range(1, 4);
                for (int i = 0; i < w; i++) begin
                    output_flag = $urandom_range(0, 1) == 1;
                    out_data    = v;
                    tick();
                    chk("rnd.waiting", {31'b0, waiting_input}, 32'd1);
                    chk_regs("rnd.wait");
                end
                output_flag = 1'b0;
                press_and_expect(sw, 1'b0);
                settle_idle(LAT + 2);
            end
        end

`ifdef IO_DEBOUNCE_EN
        // Bouncing button shorter than the filter never captures.
        input_flag = 1'b1;
        tick();
        for (int p = 0; p < 8; p++) begin
            confirm_btn = (p % 2) == 0;
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("db.bounce_in_valid", {31'b0, in_valid}, 32'd0);
                chk("db.bounce_waiting", {31'b0, waiting_input}, 32'd1);
            end
        end
        confirm_btn = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            tick();
            chk("db.quiet_in_valid", {31'b0, in_valid}, 32'd0);
        end
        press_and_expect(16'h00C3, 1'b0);
        settle_idle(LAT + 2);
`endif

        // Halt wins over a simultaneous input, then absorbs everything.
        halt       = 1'b1;
        input_flag = 1'b1;
        #1;
        chk("halt.stall_pre", {31'b0, stall}, 32'd1);
        tick();
        halt        = 1'b0;
        input_flag  = 1'b0;
        output_flag = 1'b1;
        out_data    = 32'hDEAD_BEEF;
        confirm_btn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) confirm_btn = 1'b0;
            #1;
            chk("halt.halted", {31'b0, halted}, 32'd1);
            chk("halt.stall", {31'b0, stall}, 32'd1);
            chk("halt.waiting", {31'b0, waiting_input}, 32'd0);
            chk("halt.in_valid", {31'b0, in_valid}, 32'd0);
            chk_regs("halt");
            tick();
        end
        output_flag = 1'b0;
        do_reset();

        // Reset while waiting discards the pending input.
        input_flag = 1'b1;
        tick();
        press_and_expect(16'($urandom) | 16'h0001, 1'b0);
        settle_idle(LAT + 2);
        input_flag = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("midwait.waiting", {31'b0, waiting_input}, 32'd1);
        input_flag = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("midwait.in_valid", {31'b0, in_valid}, 32'd0);
            chk("midwait.waiting_after", {31'b0, waiting_input}, 32'd0);
            chk_regs("midwait");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
